// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the integer-to-float converter and the adder datapath.
package fp_pkg;

    localparam int FP_BIAS     = 127;
    localparam int INT_EXP_TOP = 158;
    localparam int FRAC_W      = 23;
    localparam int EXP_W       = 8;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } conv_state_t;

endpackage

// File: rtl/fp_round_unit.sv
// Combinational rounding of a normalized magnitude into an IEEE-754 fraction and exponent.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_round_unit
    import fp_pkg::*;
(
    input  logic [30:0]       mag,
    input  logic [EXP_W-1:0]  exp,
    output logic [FRAC_W-1:0] frac,
    output logic [EXP_W-1:0]  exp_adj,
    output logic              inexact
);

    logic            guard;
    logic            sticky;
    logic            round_up;
    logic [FRAC_W:0] frac_sum;

    // A carry out of the fraction bumps the exponent and leaves the fraction at zero.
    always_comb begin
        guard   = mag[7];
        sticky  = |mag[6:0];
        inexact = guard | sticky;
`ifdef ROUND_NEAREST_EN
        round_up = guard & (sticky | mag[8]);
`else
        round_up = 1'b0;
`endif
        frac_sum = {1'b0, mag[30:8]} + {{FRAC_W{1'b0}}, round_up};
        frac     = frac_sum[FRAC_W-1:0];
        exp_adj  = exp + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
    end

endmodule

// File: rtl/int_to_float_converter.sv
// Multi-cycle 32-bit integer to single-precision converter with iterative normalization.
// Rounding mode is selected by the ROUND_NEAREST_EN macro inside fp_round_unit.
module int_to_float_converter
    import fp_pkg::*;
#(
    parameter int SIGNED_INPUT = 1,
    parameter int SHIFT_STEP   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_int,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        out_inexact
);

    conv_state_t      state_q, state_d;
    logic [31:0]      int_q, int_d;
    logic [31:0]      mag_q, mag_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;
    fp32_t            res_q, res_d;
    logic             inexact_q, inexact_d;

    logic              abs_sign;
    logic [31:0]       abs_mag;
    logic [FRAC_W-1:0] rnd_frac;
    logic [EXP_W-1:0]  rnd_exp;
    logic              rnd_inexact;

    fp_round_unit u_round (
        .mag     (mag_q[30:0]),
        .exp     (exp_q),
        .frac    (rnd_frac),
        .exp_adj (rnd_exp),
        .inexact (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            int_q     <= '0;
            mag_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            res_q     <= '0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            res_q     <= res_d;
            inexact_q <= inexact_d;
        end
    end

    // A zero operand takes the ROUND slot too, so its result is registered like any other.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_ABS;
            ST_ABS:   state_d = (abs_mag == '0) ? ST_ROUND : ST_NORM;
            ST_NORM:  if (mag_q[31]) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -2^31 negates onto itself, which is exactly the magnitude 0x80000000 we want.
    always_comb begin
        abs_sign = (SIGNED_INPUT != 0) ? int_q[31] : 1'b0;
        abs_mag  = abs_sign ? (~int_q + 32'd1) : int_q;
    end

    always_comb begin
        int_d     = int_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        res_d     = res_q;
        inexact_d = inexact_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) int_d = in_int;
            end
            ST_ABS: begin
                mag_d  = abs_mag;
                sign_d = abs_sign;
                exp_d  = EXP_W'(INT_EXP_TOP);
                zero_d = (abs_mag == '0);
            end
            ST_NORM: begin
                // Coarse shift only when it cannot push the leading one out of the top bit.
                if (mag_q[31 -: SHIFT_STEP] == '0) begin
                    mag_d = mag_q << SHIFT_STEP;
                    exp_d = exp_q - EXP_W'(SHIFT_STEP);
                end else if (!mag_q[31]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            ST_ROUND: begin
                if (zero_q) begin
                    res_d     = '0;
                    inexact_d = 1'b0;
                end else begin
                    res_d.sign = sign_q;
                    res_d.exp  = rnd_exp;
                    res_d.frac = rnd_frac;
                    inexact_d  = rnd_inexact;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        in_ready    = (state_q == ST_IDLE) && rst_n;
        out_valid   = (state_q == ST_DONE);
        out_float   = res_q;
        out_inexact = inexact_q;
    end

endmodule
